pipeline_hazard_ctrl: RTL
=========================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Detects load-use, taken-branch, multiply/divide-busy and memory-wait conditions every cycle.
//  Drives the per-stage enable and flush for each pipeline register.
//  Owns the mult/div occupancy timer, a done pulse and a saturating stall-cycle performance counter.
// PARAMETERS
//  REG_AW       5   register-address width
//  MULT_CYCLES  4   EX-issue-to-result latency of MULT/MULTU, in cycles (>=1)
//  DIV_CYCLES   32  EX-issue-to-result latency of DIV/DIVU, in cycles (>=1)
//  CNT_W        32  stall_cycles width
// PORTS
//  clk              in   1       rising-edge clock, the only clock
//  rst              in   1       synchronous reset, active-high
//  id_rs, id_rt     in   REG_AW  source registers of the instruction in ID
//  id_uses_rs/rt    in   1       ID instruction actually reads rs / rt
//  id_md_read       in   1       ID instruction is MFHI/MFLO
//  ex_mem_read      in   1       EX instruction is a load
//  ex_rd            in   REG_AW  destination register of the EX instruction
//  ex_md_start      in   1       EX instruction is MULT/MULTU/DIV/DIVU
//  ex_md_is_div     in   1       qualifies ex_md_start: 1 = divide
//  ex_branch_taken  in   1       branch/jump resolved taken in EX
//  mem_ready        in   1       data memory ready; 0 = MEM access still pending
//  pc_en, ifid_en, idex_en, exmem_en, memwb_en  out 1  register load enables
//  ifid_flush, idex_flush, exmem_flush          out 1  load a bubble (NOP) on this edge
//  md_busy          out  1       mult/div unit occupied
//  md_done          out  1       one-cycle pulse on the last busy cycle
//  stall_cycles     out  CNT_W   saturating count of cycles with pc_en==0
// BEHAVIOUR
//  - Enables/flushes are combinational from inputs and registered state.
//  - Registered state: md state, md counter, stall_cycles.
//  - Reset (rst=1 at an edge): md state IDLE, counter 0, stall_cycles 0.
//  - While rst is high, outputs are all en=1, all flush=1, md_busy=0, md_done=0.
//  - Per-cycle priority, highest first; absent any condition, all en=1 and all flush=0:
//    1 MEM_WAIT (mem_ready=0): all en=0, all flush=0 (full freeze).
//    2 MD_STRUCT (ex_md_start & md_busy): pc/ifid/idex en=0, exmem_flush=1; memwb proceeds.
//    3 BRANCH (ex_branch_taken): pc_en=1, ifid_flush=1, idex_flush=1.
//      Branch overrides 4 and 5 because the ID instruction is wrong-path.
//    4 LOAD_USE (ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))):
//      pc_en=0, ifid_en=0, idex_flush=1.
//    5 MD_READ (id_md_read & md_busy & ~md_done): same stall pattern as LOAD_USE.
//      MFHI/MFLO issued in the md_done cycle is NOT stalled.
//  - Flush and enable are never both 0 on the same register while it must bubble: flush implies load.
//  - MD FSM
//    - IDLE -> BUSY when ex_md_start & exmem_en (EX actually advances).
//      counter <= (ex_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1.
//    - BUSY: counter decrements every cycle, including during MEM_WAIT (the unit runs independently).
//    - BUSY & counter==0: md_done=1; next state IDLE.
//      If ex_md_start & exmem_en in that same cycle, go straight back to BUSY with a new load.
//    - md_busy = (state==BUSY).
//  - For latency 1 (CYCLES=1): a single BUSY cycle in which md_done=1.
//  - stall_cycles increments when pc_en==0 & rst==0; it holds at 2^CNT_W-1 (no wrap).
//  - rst mid-BUSY aborts the operation: IDLE next cycle, no md_done pulse.
// STRUCTURE
//  - Shared header pipe_defs.vh: MD state encodings, NOP encoding, REG_AW default, stage-index localparams.
//  - Sub-module md_timer: the MD FSM plus down-counter.
//    - Inputs: start, is_div, advance.
//    - Outputs: busy, done.
//  - Hazard priority logic and stall_cycles stay in this top module.
// TESTING
//  1 Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1
//    -> pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle.
//    Same with ex_rd=0 -> no stall.
//  2 Branch vs load-use: load-use condition plus ex_branch_taken=1
//    -> pc_en=1, ifid_flush=1, idex_flush=1, no stall.
//  3 DIV issue: ex_md_start=1, is_div=1, DIV_CYCLES=32 -> md_busy high 32 cycles, md_done on the 32nd.
//    MFLO in ID stalls cycles 1-31 and passes on cycle 32.
//  4 Back-to-back MULT: second ex_md_start while busy -> exmem_flush=1, front stalled until md_done.
//    Second MULT then issues in the done cycle; md_busy never drops.
//  5 mem_ready=0 for 3 cycles during a MULT -> all en=0.
//    Counter still expires on schedule; stall_cycles += 3.
//  6 rst at cycle 10 of a DIV -> md_busy=0 next cycle, no md_done, stall_cycles=0.
//    Saturation: preload near max -> holds at 2^CNT_W-1.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    // Mult/div occupancy FSM states.
    typedef enum logic [0:0] {
        MdIdle,
        MdBusy
    } md_state_e;

    // Index of each pipeline register in the stage enable/flush vectors.
    localparam int unsigned StageIfId  = 0;
    localparam int unsigned StageIdEx  = 1;
    localparam int unsigned StageExMem = 2;
    localparam int unsigned StageMemWb = 3;
    localparam int unsigned NumStages  = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_md_timer.sv
// Mult/div occupancy timer: tracks one in-flight MULT/DIV and pulses done on its last cycle.
module pipeline_hazard_ctrl_md_timer
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic is_div_i,
    input  logic advance_i,
    output logic busy_o,
    output logic done_o
);

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
    localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

    md_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic            busy_q;
    logic            done_q;
    logic [CntW-1:0] load_val;
    logic            launch;

    assign load_val = is_div_i ? DivLoad : MultLoad;
    // A new operation is accepted only when the EX instruction really leaves EX.
    assign launch   = start_i & advance_i;

    // FSM, down-counter and registered busy/done; the counter runs regardless of pipeline stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= MdIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                MdIdle: begin
                    if (launch) begin
                        state_q <= MdBusy;
                        cnt_q   <= load_val;
                        busy_q  <= 1'b1;
                        done_q  <= (load_val == '0);
                    end
                end
                MdBusy: begin
                    if (cnt_q == '0) begin
                        if (launch) begin
                            cnt_q  <= load_val;
                            done_q <= (load_val == '0);
                        end else begin
                            state_q <= MdIdle;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q  <= cnt_q - 1'b1;
                        done_q <= (cnt_q == CntW'(1));
                    end
                end
            endcase
        end
    end

    // Outputs read as idle while reset is held, even before the reset edge lands.
    assign busy_o = busy_q & ~rst_i;
    assign done_o = done_q & ~rst_i;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MULT_CYCLES = 4,
    parameter int unsigned DIV_CYCLES  = 32,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rs_i,
    input  logic              id_uses_rt_i,
    input  logic              id_md_read_i,
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              ex_md_start_i,
    input  logic              ex_md_is_div_i,
    input  logic              ex_branch_taken_i,
    input  logic              mem_ready_i,
    output logic              pc_en_o,
    output logic              ifid_en_o,
    output logic              idex_en_o,
    output logic              exmem_en_o,
    output logic              memwb_en_o,
    output logic              ifid_flush_o,
    output logic              idex_flush_o,
    output logic              exmem_flush_o,
    output logic              md_busy_o,
    output logic              md_done_o,
    output logic [CNT_W-1:0]  stall_cycles_o
);

    logic                 md_busy;
    logic                 md_done;
    logic                 load_use;
    logic                 md_read_haz;
    logic                 md_struct_haz;
    logic                 pc_en;
    logic [NumStages-1:0] stage_en;
    logic [NumStages-1:0] stage_flush;
    logic [CNT_W-1:0]     stall_q;
    logic [CNT_W-1:0]     stall_d;

    assign load_use = ex_mem_read_i && (ex_rd_i != '0) &&
                      ((id_uses_rs_i && (id_rs_i == ex_rd_i)) ||
                       (id_uses_rt_i && (id_rt_i == ex_rd_i)));

    // In the done cycle the result is ready: MFHI/MFLO and a new MULT/DIV may both proceed.
    assign md_read_haz   = id_md_read_i  && md_busy && !md_done;
    assign md_struct_haz = ex_md_start_i && md_busy && !md_done;

    // Priority resolution of hazards into per-stage enables and flushes; a flush always loads.
    always_comb begin
        pc_en       = 1'b1;
        stage_en    = '1;
        stage_flush = '0;
        if (rst_i) begin
            stage_flush[StageIfId]  = 1'b1;
            stage_flush[StageIdEx]  = 1'b1;
            stage_flush[StageExMem] = 1'b1;
        end else if (!mem_ready_i) begin
            pc_en    = 1'b0;
            stage_en = '0;
        end else if (md_struct_haz) begin
            pc_en                   = 1'b0;
            stage_en[StageIfId]     = 1'b0;
            stage_en[StageIdEx]     = 1'b0;
            stage_flush[StageExMem] = 1'b1;
        end else if (ex_branch_taken_i) begin
            stage_flush[StageIfId] = 1'b1;
            stage_flush[StageIdEx] = 1'b1;
        end else if (load_use || md_read_haz) begin
            pc_en                  = 1'b0;
            stage_en[StageIfId]    = 1'b0;
            stage_flush[StageIdEx] = 1'b1;
        end
    end

    pipeline_hazard_ctrl_md_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (ex_md_start_i),
        .is_div_i  (ex_md_is_div_i),
        .advance_i (stage_en[StageExMem] & ~stage_flush[StageExMem]),
        .busy_o    (md_busy),
        .done_o    (md_done)
    );

    // Saturating count of cycles in which the PC is held.
    always_comb begin
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // Performance counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign pc_en_o        = pc_en;
    assign ifid_en_o      = stage_en[StageIfId];
    assign idex_en_o      = stage_en[StageIdEx];
    assign exmem_en_o     = stage_en[StageExMem];
    assign memwb_en_o     = stage_en[StageMemWb];
    assign ifid_flush_o   = stage_flush[StageIfId];
    assign idex_flush_o   = stage_flush[StageIdEx];
    assign exmem_flush_o  = stage_flush[StageExMem];
    assign md_busy_o      = md_busy;
    assign md_done_o      = md_done;
    assign stall_cycles_o = stall_q;

endmodule
